// File: rtl/io_fifo_interface.sv
// Memory-mapped UART FIFO bridge: TX/RX byte FIFOs, sticky TX overflow flag,
// and free-running cycle / retired-instruction counters behind a 0x8xxxxxxx window.
module io_fifo_interface #(
  parameter int unsigned TX_DEPTH  = 8,
  parameter int unsigned RX_DEPTH  = 8,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [31:0] rd2,
  input  logic [3:0]  IO_trans,
  input  logic        IO_recv,
  input  logic        Stall,
  output logic [31:0] Received,
  output logic [7:0]  DataIn,
  output logic        DataInValid,
  input  logic        DataInReady,
  input  logic [7:0]  DataOut,
  input  logic        DataOutValid,
  output logic        DataOutReady
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;

  localparam logic [7:0] REG_STATUS  = 8'h00;
  localparam logic [7:0] REG_RX_DATA = 8'h04;
  localparam logic [7:0] REG_TX_DATA = 8'h08;
  localparam logic [7:0] REG_CTRL    = 8'h0C;
  localparam logic [7:0] REG_CYCLES  = 8'h10;
  localparam logic [7:0] REG_INSTRS  = 8'h14;
  localparam logic [7:0] REG_CNT_CLR = 8'h18;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr, tx_rd;
  logic [TX_CW-1:0] tx_count;
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr, rx_rd;
  logic [RX_CW-1:0] rx_count;
  logic             tx_overflow;
  logic [CNT_WIDTH-1:0] cycles, instrs;

  logic       mapped, wr_en, rd_en;
  logic [7:0] sel;
  logic       tx_full, tx_pop, tx_push_req, tx_push, ovf_set, ovf_clr;
  logic       rx_empty, rx_full, rx_push, rx_pop, flush, cnt_clr;
  logic       unused_bits;

  assign unused_bits = ^{Addr[27:8], rd2[31:8]};

  assign mapped = (Addr[31:28] == 4'h8);
  assign sel    = Addr[7:0];
  assign wr_en  = mapped && !Stall && (IO_trans != 4'h0);
  assign rd_en  = mapped && !Stall && IO_recv;

  assign tx_full      = (tx_count == TX_CW'(TX_DEPTH));
  assign rx_empty     = (rx_count == '0);
  assign rx_full      = (rx_count == RX_CW'(RX_DEPTH));

  assign DataInValid  = (tx_count != '0);
  assign DataIn       = tx_mem[tx_rd];
  assign DataOutReady = !rx_full;

  // A push into a full TX FIFO is still accepted when the UART drains a byte on the same edge.
  assign tx_pop      = DataInValid && DataInReady;
  assign tx_push_req = wr_en && (sel == REG_TX_DATA);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign ovf_set     = tx_push_req && tx_full && !tx_pop;
  assign ovf_clr     = wr_en && (sel == REG_CTRL) && rd2[0];
  assign flush       = wr_en && (sel == REG_CTRL) && rd2[1];
  assign cnt_clr     = wr_en && (sel == REG_CNT_CLR);
  assign rx_push     = DataOutValid && DataOutReady;
  assign rx_pop      = rd_en && (sel == REG_RX_DATA) && !rx_empty;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else if (flush) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TX_AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + TX_AW'(1);
      tx_count <= tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);
    end
  end

  always_ff @(posedge Clock) begin
    if (tx_push) tx_mem[tx_wr] <= rd2[7:0];
    if (rx_push) rx_mem[rx_wr] <= DataOut;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else if (flush) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + RX_AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + RX_AW'(1);
      rx_count <= rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)       tx_overflow <= 1'b0;
    else if (ovf_set) tx_overflow <= 1'b1;
    else if (ovf_clr) tx_overflow <= 1'b0;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cycles <= '0;
      instrs <= '0;
    end else if (cnt_clr) begin
      cycles <= '0;
      instrs <= '0;
    end else begin
      cycles <= cycles + CNT_WIDTH'(1);
      if (!Stall) instrs <= instrs + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    Received = '0;
    if (mapped) begin
      case (sel)
        REG_STATUS:  Received = {8'h00, 8'(tx_count), 8'(rx_count), 5'b00000,
                                 tx_overflow, !rx_empty, !tx_full};
        REG_RX_DATA: Received = {24'h000000, rx_empty ? 8'h00 : rx_mem[rx_rd]};
        REG_CYCLES:  Received = 32'(cycles);
        REG_INSTRS:  Received = 32'(instrs);
        default:     Received = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_fifo_interface.sv
// Bench for io_fifo_interface: directed scenarios plus random traffic, all checked
// against a queue-based model of the register map and FIFOs.
module tb_io_fifo_interface;
  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] Addr, rd2, Received;
  logic [3:0]  IO_trans;
  logic        IO_recv, Stall;
  logic [7:0]  DataIn, DataOut;
  logic        DataInValid, DataInReady, DataOutValid, DataOutReady;

  io_fifo_interface #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .CNT_WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .Addr(Addr), .rd2(rd2), .IO_trans(IO_trans),
    .IO_recv(IO_recv), .Stall(Stall), .Received(Received),
    .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
    .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  byte unsigned tx_q[$];
  byte unsigned rx_q[$];
  bit           ovf;
  bit [31:0]    cyc, ins;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    bit tnf, rne;
    tnf = (tx_q.size() < TXD);
    rne = (rx_q.size() != 0);
    if (a[31:28] != 4'h8) return 32'h0;
    case (a[7:0])
      8'h00: return {8'h00, 8'(tx_q.size()), 8'(rx_q.size()), 5'b0, ovf, rne, tnf};
      8'h04: return rne ? {24'h0, rx_q[0]} : 32'h0;
      8'h10: return cyc;
      8'h14: return ins;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    ovf = 0;
    cyc = 0;
    ins = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    bit acc, wr, rd, tx_pop, tx_push, rx_pop, rx_push, fl, oclr, cclr, oset;
    logic [7:0] r;
    if (!Reset) begin
      model_reset();
      return;
    end
    acc     = !Stall && (Addr[31:28] == 4'h8);
    r       = Addr[7:0];
    wr      = acc && (IO_trans != 0);
    rd      = acc && IO_recv;
    tx_pop  = (tx_q.size() > 0) && DataInReady;
    tx_push = wr && (r == 8'h08);
    rx_push = DataOutValid && (rx_q.size() < RXD);
    rx_pop  = rd && (r == 8'h04) && (rx_q.size() > 0);
    fl      = wr && (r == 8'h0C) && rd2[1];
    oclr    = wr && (r == 8'h0C) && rd2[0];
    cclr    = wr && (r == 8'h18);
    oset    = tx_push && (tx_q.size() == TXD) && !tx_pop;
    if (fl) begin
      tx_q.delete();
      rx_q.delete();
    end else begin
      if (tx_pop) void'(tx_q.pop_front());
      if (tx_push && tx_q.size() < TXD) tx_q.push_back(rd2[7:0]);
      if (rx_pop) void'(rx_q.pop_front());
      if (rx_push) rx_q.push_back(DataOut);
    end
    if (oset) ovf = 1;
    else if (oclr) ovf = 0;
    if (cclr) begin
      cyc = 0;
      ins = 0;
    end else begin
      cyc = cyc + 1;
      if (!Stall) ins = ins + 1;
    end
  endtask

  // Called right at a falling edge with inputs set; checks outputs, then crosses one rising edge.
  task automatic cycle();
    #1;
    check("rdata", Received, exp_rd(Addr));
    check("din_valid", 32'(DataInValid), 32'(tx_q.size() != 0));
    if (tx_q.size() != 0) check("din", 32'(DataIn), 32'(tx_q[0]));
    check("dout_ready", 32'(DataOutReady), 32'(rx_q.size() < RXD));
    model_step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic idle();
    Addr = 32'h0; rd2 = 32'h0; IO_trans = 4'h0; IO_recv = 1'b0; Stall = 1'b0;
    DataInReady = 1'b0; DataOutValid = 1'b0; DataOut = 8'h00;
  endtask

  task automatic wr_reg(input logic [7:0] off, input logic [31:0] data);
    Addr = BASE | 32'(off); rd2 = data; IO_trans = 4'hF;
    cycle();
    IO_trans = 4'h0; Addr = 32'h0;
  endtask

  logic [7:0] offs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};

  initial begin
    idle();
    Reset = 1'b0;
    model_reset();
    @(negedge Clock);
    Addr = BASE;
    #1;
    check("rst_status", Received, 32'h1);
    check("rst_din_valid", 32'(DataInValid), 32'h0);
    check("rst_dout_ready", 32'(DataOutReady), 32'h1);
    @(negedge Clock);
    Reset = 1'b1;
    Addr = BASE;
    cycle();

    // two TX bytes drained in order
    wr_reg(8'h08, 32'hAA);
    wr_reg(8'h08, 32'h55);
    DataInReady = 1'b1;
    #1 check("tx_first", 32'(DataIn), 32'hAA);
    cycle();
    #1 check("tx_second", 32'(DataIn), 32'h55);
    cycle();
    #1 check("tx_drained", 32'(DataInValid), 32'h0);
    DataInReady = 1'b0;

    // TX overflow, then clear
    for (int i = 0; i < 9; i++) wr_reg(8'h08, 32'(i + 16));
    Addr = BASE;
    #1;
    check("ovf_txcnt", 32'(Received[23:16]), 32'd8);
    check("ovf_notfull", 32'(Received[0]), 32'd0);
    check("ovf_flag", 32'(Received[2]), 32'd1);
    wr_reg(8'h0C, 32'h1);
    Addr = BASE;
    #1 check("ovf_cleared", 32'(Received[2]), 32'd0);
    wr_reg(8'h0C, 32'h2);

    // RX fill to full, read back in order
    DataOutValid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      DataOut = 8'(i);
      cycle();
    end
    DataOutValid = 1'b0;
    Addr = BASE;
    #1;
    check("rx_full_ready", 32'(DataOutReady), 32'd0);
    check("rx_count8", 32'(Received[15:8]), 32'd8);
    for (int i = 1; i <= 9; i++) begin
      Addr = BASE | 32'h04;
      IO_recv = 1'b1;
      #1 check("rx_pop", Received, (i <= 8) ? 32'(i) : 32'h0);
      cycle();
    end
    IO_recv = 1'b0;

    // simultaneous push/pop: TX full, RX with one entry, TX empty pass-through
    for (int i = 0; i < 8; i++) wr_reg(8'h08, 32'(8'hC0 + i));
    DataInReady = 1'b1;
    wr_reg(8'h08, 32'h77);
    Addr = BASE;
    #1;
    check("full_pp_cnt", 32'(Received[23:16]), 32'd8);
    check("full_pp_ovf", 32'(Received[2]), 32'd0);
    for (int i = 0; i < 8; i++) cycle();
    #1 check("full_pp_last", 32'(DataInValid), 32'd0);
    wr_reg(8'h08, 32'h99);
    #1 check("empty_pp_data", 32'(DataIn), 32'h99);
    cycle();
    DataInReady = 1'b0;
    DataOutValid = 1'b1; DataOut = 8'h3C;
    cycle();
    DataOut = 8'h5A; Addr = BASE | 32'h04; IO_recv = 1'b1;
    cycle();
    DataOutValid = 1'b0; IO_recv = 1'b0; Addr = BASE;
    #1 check("rx_pp_cnt", 32'(Received[15:8]), 32'd1);
    Addr = BASE | 32'h04;
    #1 check("rx_pp_data", Received, 32'h5A);
    IO_recv = 1'b1;
    cycle();
    IO_recv = 1'b0;

    // counters with stalls
    wr_reg(8'h18, 32'h0);
    for (int i = 0; i < 20; i++) begin
      Stall = (i % 4 == 1);
      cycle();
    end
    Stall = 1'b0;
    Addr = BASE | 32'h10;
    #1 check("cycles20", Received, 32'd20);
    Addr = BASE | 32'h14;
    #1 check("instrs15", Received, 32'd15);
    wr_reg(8'h18, 32'h1);
    Addr = BASE | 32'h10;
    #1 check("cycles_clr", Received, 32'd0);
    Addr = BASE | 32'h14;
    #1 check("instrs_clr", Received, 32'd0);

    // async reset mid-burst
    for (int i = 0; i < 3; i++) wr_reg(8'h08, 32'(8'hE0 + i));
    DataOutValid = 1'b1; DataOut = 8'h42;
    cycle();
    cycle();
    #1 Reset = 1'b0;
    #1;
    check("arst_din_valid", 32'(DataInValid), 32'd0);
    check("arst_dout_ready", 32'(DataOutReady), 32'd1);
    Addr = BASE;
    #1 check("arst_status", Received, 32'h1);
    Addr = BASE | 32'h10;
    #1 check("arst_cycles", Received, 32'd0);
    Addr = BASE | 32'h14;
    #1 check("arst_instrs", Received, 32'd0);
    model_reset();
    @(negedge Clock);
    cycle();
    Reset = 1'b1;
    idle();
    cycle();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      int unsigned k;
      k = $urandom_range(0, 8);
      if (k < 8) Addr = BASE | ($urandom & 32'h0FFF_FF00) | 32'(offs[k]);
      else Addr = {4'($urandom_range(0, 7)), 28'($urandom)};
      rd2 = $urandom;
      IO_trans = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (k == 3 && $urandom_range(0, 7) != 0) rd2[1] = 1'b0;
      if (k == 6 && $urandom_range(0, 3) != 0) IO_trans = 4'h0;
      IO_recv      = 1'($urandom_range(0, 1));
      Stall        = ($urandom_range(0, 3) == 0);
      DataInReady  = 1'($urandom_range(0, 1));
      DataOutValid = 1'($urandom_range(0, 1));
      DataOut      = 8'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
